// File: rtl/struct_rec_pkg.sv
// Shared record/field types and the field-walk helper used by both the record
// writer and reader.
package struct_rec_pkg;

  localparam int X_W_DEF = 32;
  localparam int Z_W_DEF = 4;

  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic               y;
    logic [Z_W_DEF-1:0] z;
  } rec_t;

  typedef enum logic [1:0] {
    FLD_X = 2'd0,
    FLD_Y = 2'd1,
    FLD_Z = 2'd2
  } fld_sel_e;

  // Passing SEL_NONE as cur asks for the first enabled field of the record.
  localparam logic [1:0] SEL_NONE = 2'd3;

  typedef struct packed {
    logic     found;
    fld_sel_e sel;
    logic     last;
  } nxt_t;

  // Returns the lowest enabled field after cur and whether nothing follows it.
  function automatic nxt_t next_field(input logic [2:0] mask, input logic [1:0] cur);
    nxt_t r;
    r       = '0;
    r.sel   = FLD_X;
    r.found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!r.found && mask[i] && (cur == SEL_NONE || i > int'(cur))) begin
        r.found = 1'b1;
        r.sel   = fld_sel_e'(i[1:0]);
      end
    end
    r.last = r.found;
    for (int i = 0; i < 3; i++) begin
      if (r.found && mask[i] && i > int'(r.sel)) r.last = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/struct_rec_reader.sv
// Takes one {x,y,z} record per load handshake and streams its enabled fields,
// zero-extended and tagged, one per beat on a valid/ready field bus.
module struct_rec_reader
  import struct_rec_pkg::*;
#(
  parameter int X_W   = 32,
  parameter int Z_W   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [X_W-1:0]   load_x,
  input  logic             load_y,
  input  logic [Z_W-1:0]   load_z,
  input  logic [2:0]       load_mask,
  output logic             fld_valid,
  input  logic             fld_ready,
  output logic [1:0]       fld_sel,
  output logic [X_W-1:0]   fld_data,
  output logic             fld_last,
  output logic [CNT_W-1:0] rec_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_X = 2'd1,
    SEND_Y = 2'd2,
    SEND_Z = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q;
  logic           y_q;
  logic [Z_W-1:0] z_q;
  logic [2:0]     mask_q;
  fld_sel_e       sel_q, sel_d;
  logic [X_W-1:0] data_q, data_d;
  logic           last_q, last_d;
  logic           cnt_inc;
  logic           accept;
  nxt_t           nx;

  function automatic logic [X_W-1:0] fdata(input fld_sel_e s, input logic [X_W-1:0] x,
                                           input logic y, input logic [Z_W-1:0] z);
    case (s)
      FLD_X:   fdata = x;
      FLD_Y:   fdata = {{(X_W-1){1'b0}}, y};
      FLD_Z:   fdata = {{(X_W-Z_W){1'b0}}, z};
      default: fdata = '0;
    endcase
  endfunction

  function automatic state_e to_state(input fld_sel_e s);
    case (s)
      FLD_X:   to_state = SEND_X;
      FLD_Y:   to_state = SEND_Y;
      default: to_state = SEND_Z;
    endcase
  endfunction

  assign load_ready = (state_q == IDLE);
  assign accept     = load_valid && load_ready;
  assign fld_valid  = (state_q != IDLE);
  assign fld_sel    = sel_q;
  assign fld_data   = data_q;
  assign fld_last   = last_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_inc = 1'b0;
    nx      = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // First beat is built straight from the load inputs so it is
          // presented the cycle after acceptance.
          nx = next_field(load_mask, SEL_NONE);
          if (nx.found) begin
            state_d = to_state(nx.sel);
            sel_d   = nx.sel;
            data_d  = fdata(nx.sel, load_x, load_y, load_z);
            last_d  = nx.last;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        if (fld_ready) begin
          if (last_q) begin
            state_d = IDLE;
            sel_d   = FLD_X;
            data_d  = '0;
            last_d  = 1'b0;
            cnt_inc = 1'b1;
          end else begin
            nx      = next_field(mask_q, sel_q);
            state_d = to_state(nx.sel);
            sel_d   = nx.sel;
            data_d  = fdata(nx.sel, x_q, y_q, z_q);
            last_d  = nx.last;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= FLD_X;
      data_q  <= '0;
      last_q  <= 1'b0;
      rec_cnt <= '0;
      x_q     <= '0;
      y_q     <= 1'b0;
      z_q     <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      last_q  <= last_d;
      if (cnt_inc) rec_cnt <= rec_cnt + CNT_W'(1);
      if (accept) begin
        x_q    <= load_x;
        y_q    <= load_y;
        z_q    <= load_z;
        mask_q <= load_mask;
      end
    end
  end

endmodule

// File: doc/struct_rec_reader.md
Name: struct_rec_reader

Overview:
Reader counterpart to the record field writer. Accepts one complete record {x, y, z} per load handshake and streams its enabled fields out one per beat on a valid/ready field bus. Every field is zero-extended to a common data width and tagged with a field select code. Sits between the record producer and any field-wise consumer: display/log sink, serial link, or register bus.

Parameters:
X_W, 32, width of field x (int)
Z_W, 4, width of field z
CNT_W, 16, width of completed-record counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
load_valid  in  1  record offered
load_ready  out  1  block can accept a record
load_x  in  X_W  field x
load_y  in  1  field y
load_z  in  Z_W  field z
load_mask  in  3  field enables, bit0=x, bit1=y, bit2=z
fld_valid  out  1  field beat present
fld_ready  in  1  consumer accepts beat
fld_sel  out  2  0=x, 1=y, 2=z (3 never driven)
fld_data  out  X_W  field value, zero-extended
fld_last  out  1  beat is final enabled field of record
rec_cnt  out  CNT_W  records fully read since reset

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: load_ready=1, fld_valid=0, fld_sel=0, fld_data=0, fld_last=0, rec_cnt=0, state=IDLE.
- Reset mid-operation: the held record and any pending beat are discarded with no further output.
- States:
  - IDLE: load_ready=1.
  - SEND_X, SEND_Y, SEND_Z: load_ready=0.
- Load:
  - A load is accepted when load_valid and load_ready are both high at a rising edge.
  - x, y, z and mask are registered on acceptance.
- Field order: x, then y, then z. Fields whose mask bit is 0 are skipped.
- IDLE transitions on accepted load:
  - If mask is nonzero, go to the state of the lowest enabled field.
  - fld_valid rises the next cycle, giving 1-cycle latency from accept to first beat.
  - If mask is 0, stay IDLE, emit no beats, and increment rec_cnt the next cycle.
- SEND_* states:
  - fld_valid=1; fld_sel, fld_data and fld_last come from registers.
  - These outputs hold stable while fld_ready=0, with no limit on stall length.
  - On fld_valid&&fld_ready:
    - If fld_last=1, go to IDLE and increment rec_cnt.
    - Otherwise go to the next enabled field's state; the next beat appears the following cycle, with no bubble.
- Data widths:
  - y is placed in bit 0 of fld_data.
  - z is placed in bits Z_W-1:0 of fld_data.
  - All upper bits of fld_data are 0.
  - fld_data is 0 whenever fld_valid=0.
- fld_last is computed as "no enabled field after the current one".
- Back-to-back records: load_ready rises in the cycle after the final beat is accepted, so there is a minimum 1-cycle gap between records. A load_valid held high meanwhile is not lost; it is taken once load_ready is high.
- rec_cnt wraps from 2^CNT_W-1 to 0 silently.
- Inputs load_x, load_y, load_z and load_mask are ignored when no load is accepted, and changing them mid-stream has no effect.

Decomposition:
- Shared package struct_rec_pkg contains:
  - typedef struct packed rec_t {x, y, z}.
  - enum fld_sel_e {FLD_X=0, FLD_Y=1, FLD_Z=2}.
  - Function next_field(mask, cur), returning the next enabled field and a last flag; the writer side reuses this.
- No sub-module: the FSM plus output registers is one module.

Test Plan:
1. Load x=23, y=1, z=5, mask=3'b111, with fld_ready always 1 → beats (0,0x17,last0), (1,0x1,last0), (2,0x5,last1) on consecutive cycles. rec_cnt=1.
2. Same record with fld_ready low for 4 cycles on the y beat → y beat held stable all 4 cycles, no beat dropped or duplicated, then the z beat.
3. mask=3'b101 with z=4'hF → beats (0,0x17,last0), (2,0x0000000F,last1). The y beat never appears.
4. mask=3'b000 → no fld_valid. rec_cnt increments by 1 one cycle after accept. load_ready stays 1.
5. rst asserted during the SEND_Y stall → next cycle fld_valid=0, load_ready=1, rec_cnt=0. A new load then streams correctly from x.
6. Two records with load_valid held high → second load accepted exactly one cycle after the first record's last beat. Preload rec_cnt to 0xFFFF via 65535 mask-0 loads, then one more → rec_cnt wraps to 0.
